// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit that owns the MIPS HI/LO register pair.
//   MULT/MULTU/DIV/DIVU run for DATA_WIDTH+1 busy cycles: DATA_WIDTH CALC steps
//   on operand magnitudes, then one FIX cycle that applies signs and writes
//   HI/LO. MTHI/MTLO writes are accepted while idle.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   start        request an operation (sampled only while idle)
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a            rs operand: multiplicand / dividend / MTHI-MTLO data
//   b            rt operand: multiplier / divisor
//   hi_we/lo_we  MTHI / MTLO write enables (idle only)
//   busy         operation in progress (registered)
//   done         one-cycle pulse, HI/LO hold the new result
//   div_by_zero  pulses with done when a divide had b == 0
//   hi, lo       HI and LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  hi_we,
  input  logic                  lo_we,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  // Shared work register: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient}.
  logic [2*W-1:0]  work_q;
  logic [W-1:0]    opnd_q;      // multiplicand or divisor magnitude
  logic [W-1:0]    a_raw_q;     // raw dividend, returned in HI on divide by zero
  logic            is_div_q;
  logic            neg_q;       // product / quotient must be negated in FIX
  logic            rem_neg_q;   // remainder takes the dividend's sign
  logic            dbz_flag_q;
  logic [W-1:0]    hi_q, lo_q;
  logic            busy_q, done_q, dbz_q;

  // Operand magnitudes for the signed ops; unsigned ops pass straight through.
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;

  assign a_neg = ~op[0] & a[W-1];
  assign b_neg = ~op[0] & b[W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One shift-add multiply step: conditionally add the multiplicand to the
  // upper half, then shift the whole register right (carry enters at the top).
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;

  assign mul_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[W-1:1]};

  // One restoring divide step: shift the next dividend bit into the
  // remainder, trial-subtract the divisor and keep it if non-negative.
  logic [W:0]      div_shift, div_diff;
  logic [2*W-1:0]  div_next;

  assign div_shift = work_q[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[W] ? {work_q[2*W-2:0], 1'b0}
                                 : {div_diff[W-1:0], work_q[W-2:0], 1'b1};

  // Sign correction applied in FIX. The signed overflow case (most-negative
  // divided by -1) falls out naturally: magnitude 2^(W-1), positive sign.
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_mag, rem_mag, quo_fix, rem_fix;

  assign prod_fix = neg_q ? -work_q : work_q;
  assign quo_mag  = work_q[W-1:0];
  assign rem_mag  = work_q[2*W-1:W];
  assign quo_fix  = neg_q ? -quo_mag : quo_mag;
  assign rem_fix  = rem_neg_q ? -rem_mag : rem_mag;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_flag_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= a;
          if (lo_we) lo_q <= a;
          if (start) begin
            is_div_q   <= op[1];
            a_raw_q    <= a;
            opnd_q     <= op[1] ? b_mag : a_mag;
            work_q     <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
            neg_q      <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            dbz_flag_q <= op[1] & (b == '0);
            count_q    <= CW'(W);
            busy_q     <= 1'b1;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          work_q  <= is_div_q ? div_next : mul_next;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            if (dbz_flag_q) begin
              hi_q <= a_raw_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end else begin
            hi_q <= prod_fix[2*W-1:W];
            lo_q <= prod_fix[W-1:0];
          end
          done_q  <= 1'b1;
          dbz_q   <= dbz_flag_q;
          busy_q  <= 1'b0;
          count_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit: directed vector table, randomized ops
//   against an arithmetic reference model, and hand sequences for ignored
//   start, same-cycle MTHI + start, MTHI/MTLO and reset abort.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          reset, start, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clock(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition of each op.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml, output logic md);
    int          sx, sy;
    longint      sp;
    logic [63:0] up;
    sx = x;
    sy = y;
    md = 1'b0;
    mh = '0;
    ml = '0;
    case (o)
      2'd0: begin sp = longint'(sx) * longint'(sy); {mh, ml} = sp; end
      2'd1: begin up = 64'(x) * 64'(y); {mh, ml} = up; end
      2'd2: begin
        if (y == 0) begin ml = 32'hFFFF_FFFF; mh = x; md = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin ml = x; mh = '0; end
        else begin ml = sx / sy; mh = sx % sy; end
      end
      default: begin
        if (y == 0) begin ml = 32'hFFFF_FFFF; mh = x; md = 1'b1; end
        else begin ml = x / y; mh = x % y; end
      end
    endcase
  endfunction

  // Issue one operation with start in cycle 0 and follow it to done.
  // poke_cyc > 0 re-pulses start with a different op/operands in that cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int poke_cyc, input logic mthi,
                       output logic [31:0] rh, output logic [31:0] rl, output logic rd,
                       output int lat, output logic hs_ok, output logic [31:0] hi_c1);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; hi_we = mthi;
    hs_ok = (busy == 1'b0) && (done == 1'b0);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    a = $urandom; b = $urandom;   // operands must already be latched
    hi_c1 = hi;
    lat = 1;
    while (!done && lat < 60) begin
      if (!busy || div_by_zero) hs_ok = 1'b0;
      if (lat == poke_cyc) begin
        start = 1'b1; op = 2'b10; a = 32'h55; b = 32'h3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (busy) hs_ok = 1'b0;
    rh = hi; rl = lo; rd = div_by_zero;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rh, rl, mh, ml, hc1, x, y;
    logic        rd, md, ok;
    logic [1:0]  o;
    int          lat, ndone;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{2'd2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{2'd1, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, rh, rl, rd, lat, ok, hc1);
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rd, lat);
      check("vec_hi", rh, vecs[i].hi);
      check("vec_lo", rl, vecs[i].lo);
      check("vec_dbz", 32'(rd), 32'(vecs[i].dbz));
      check("vec_latency", 32'(lat), 32'(LAT));
      check("vec_busy_window", 32'(ok), 32'd1);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        3: x = 32'h8000_0000;
        default: ;
      endcase
      model(o, x, y, mh, ml, md);
      do_op(o, x, y, 0, 1'b0, rh, rl, rd, lat, ok, hc1);
      $display("rnd %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d",
               i, o, x, y, rh, rl, rd, lat);
      check("rnd_hi", rh, mh);
      check("rnd_lo", rl, ml);
      check("rnd_dbz", 32'(rd), 32'(md));
      check("rnd_latency", 32'(lat), 32'(LAT));
      check("rnd_busy_window", 32'(ok), 32'd1);
    end

    // start pulsed mid-operation is ignored
    do_op(2'd1, 32'd3, 32'd4, 10, 1'b0, rh, rl, rd, lat, ok, hc1);
    $display("ignored-start MULTU 3*4 -> hi=%h lo=%h lat=%0d", rh, rl, lat);
    check("ign_hi", rh, 32'd0);
    check("ign_lo", rl, 32'd12);
    check("ign_latency", 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    check("ign_no_second_op", 32'(busy), 32'd0);

    // Same-cycle MTHI and start: MTHI lands first, result overwrites later
    do_op(2'd1, 32'd5, 32'd6, 0, 1'b1, rh, rl, rd, lat, ok, hc1);
    $display("mthi+start MULTU 5*6 -> hi_c1=%h hi=%h lo=%h lat=%0d", hc1, rh, rl, lat);
    check("mthi_start_hi_c1", hc1, 32'd5);
    check("mthi_start_hi", rh, 32'd0);
    check("mthi_start_lo", rl, 32'd30);

    // MTHI/MTLO in idle, then reset in cycle 15 of a MULT
    @(posedge clk); #1;
    hi_we = 1'b1; a = 32'hDEAD;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; a = 32'hBEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);
    check("mthi_hi", hi, 32'hDEAD);
    check("mtlo_lo", lo, 32'hBEEF);

    start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset abort -> busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    ndone = 0;
    repeat (LAT) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("abort_no_activity", 32'(ndone), 32'd0);
    check("abort_lo_held", lo, 32'd0);

    hi_we = 1'b1; a = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    $display("mthi after reset -> hi=%h lo=%h", hi, lo);
    check("post_reset_mthi_hi", hi, 32'h1234);
    check("post_reset_mthi_lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
